// File: rtl/stack_cache_pkg.sv
// Shared types and sizing for the stack cache and its ring store.
// The spill/fill path in the top module is enabled with `define STACK_SPILL_EN.
package stack_cache_pkg;

   // Default log2 ring depth, ring size and occupancy-counter width
   localparam int DEP_DFLT = 2;
   localparam int N        = 1 << DEP_DFLT;
   localparam int CNT_W    = DEP_DFLT + 1;

   // Memory-transfer controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SPILL = 2'd1,
      ST_FILL  = 2'd2
   } state_t;

endpackage

// File: rtl/stack_ring.sv
// Ring storage for a hardware stack: 2^DEP words of L bits, one synchronous
// write port and two asynchronous read ports (top of stack and bottom of ring).
module stack_ring
   import stack_cache_pkg::*;
#(
   parameter int L   = 16,
   parameter int DEP = DEP_DFLT
) (
   input  logic           clk,
   input  logic           i_we,
   input  logic [DEP-1:0] i_waddr,
   input  logic [L-1:0]   i_wdata,
   input  logic [DEP-1:0] i_top_idx,
   input  logic [DEP-1:0] i_bot_idx,
   output logic [L-1:0]   o_top,
   output logic [L-1:0]   o_bot
);

   logic [L-1:0] r_mem [0:(1<<DEP)-1];

   // Single write port; the storage itself carries no reset
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_top = r_mem[i_top_idx];
   assign o_bot = r_mem[i_bot_idx];

endmodule

// File: rtl/stack_cache.sv
// Stack cache: an on-chip ring of 2^DEP words in front of a memory-resident
// stack. With `define STACK_SPILL_EN the oldest ring word is spilled to memory
// when a push finds the ring full, and a word is filled back when a pop finds
// it empty; the requester is stalled while a transfer is in flight. Without
// the macro the block is a plain wrap-around ring (legacy stack behaviour).
module stack_cache
   import stack_cache_pkg::*;
#(
   parameter int           L     = 16,
   parameter int           DEP   = DEP_DFLT,
   parameter logic [L-1:0] BASE  = 16'h0800,
   parameter logic [L-1:0] LIMIT = 16'h0700
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [L-1:0] din,
   output logic [L-1:0] dout,
   output logic         stall,
   output logic [DEP:0] cnt,
   output logic         ovf,
   output logic         unf,
   output logic         mem_req,
   output logic         mem_we,
   output logic [L-1:0] mem_addr,
   output logic [L-1:0] mem_wdata,
   input  logic [L-1:0] mem_rdata,
   input  logic         mem_ack
);

   localparam int           RING_N   = 1 << DEP;
   localparam logic [DEP:0] FULL_CNT = (DEP+1)'(RING_N);

   logic [DEP-1:0] r_tp;
   logic [DEP:0]   r_cnt;
   logic           r_ovf;
   logic           r_unf;

   logic           w_push_only, w_pop_only, w_both, w_full, w_empty, w_stall;
   logic           w_do_push, w_do_repl, w_do_pop, w_ovf_set, w_unf_set;
   logic [DEP-1:0] w_tp_inc, w_tp_dec, w_bot_idx, w_waddr;
   logic           w_we;
   logic [L-1:0]   w_wdata, w_rd_top, w_rd_bot;

   assign w_push_only = push & ~pop;
   assign w_pop_only  = pop & ~push;
   assign w_both      = push & pop;
   assign w_full      = (r_cnt == FULL_CNT);
   assign w_empty     = (r_cnt == '0);
   assign w_tp_inc    = r_tp + 1'b1;
   assign w_tp_dec    = r_tp - 1'b1;
   // Oldest ring entry; when full this coincides with tp + 1
   assign w_bot_idx   = r_tp - r_cnt[DEP-1:0] + 1'b1;

`ifdef STACK_SPILL_EN
   state_t       r_state;
   logic [L-1:0] r_msp;
   logic         r_mem_req, r_mem_we;
   logic [L-1:0] r_mem_addr, r_mem_wdata;
   logic         w_idle, w_spill_go, w_fill_go, w_fill_done;

   assign w_idle      = (r_state == ST_IDLE);
   assign w_spill_go  = w_idle & w_push_only & w_full & (r_msp != LIMIT);
   assign w_fill_go   = w_idle & w_pop_only & w_empty & (r_msp != BASE);
   assign w_fill_done = (r_state == ST_FILL) & mem_ack;
   assign w_stall     = ~w_idle | w_spill_go | w_fill_go;

   // A full ring only drops the push once memory is also full (msp at LIMIT)
   assign w_do_push = ~w_stall & ((w_both & w_empty) | (w_push_only & ~w_full));
   assign w_ovf_set = ~w_stall & w_push_only & w_full;
   assign w_unf_set = ~w_stall & w_pop_only & w_empty;

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
`else
   logic w_unused;

   assign w_stall   = 1'b0;
   // A push into a full ring overwrites the oldest entry
   assign w_do_push = (w_both & w_empty) | w_push_only;
   assign w_ovf_set = w_push_only & w_full;
   assign w_unf_set = w_pop_only & w_empty;

   assign mem_req   = 1'b0;
   assign mem_we    = 1'b0;
   assign mem_addr  = '0;
   assign mem_wdata = '0;
   assign w_unused  = ^{mem_rdata, mem_ack, w_rd_bot, BASE, LIMIT};
`endif

   assign w_do_repl = ~w_stall & w_both & ~w_empty;
   assign w_do_pop  = ~w_stall & w_pop_only & ~w_empty;

   // Ring write select: new top on push, current top on replace or refill
   always_comb begin
      w_we    = w_do_push | w_do_repl;
      w_waddr = w_do_push ? w_tp_inc : r_tp;
      w_wdata = din;
`ifdef STACK_SPILL_EN
      if (w_fill_done) begin
         w_we    = 1'b1;
         w_waddr = r_tp;
         w_wdata = mem_rdata;
      end
`endif
   end

   stack_ring #(
      .L   (L),
      .DEP (DEP)
   ) u_ring (
      .clk       (clk),
      .i_we      (w_we),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_top_idx (r_tp),
      .i_bot_idx (w_bot_idx),
      .o_top     (w_rd_top),
      .o_bot     (w_rd_bot)
   );

   // Ring pointers, sticky flags and the spill/fill controller
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
`ifdef STACK_SPILL_EN
         r_state     <= ST_IDLE;
         r_msp       <= BASE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
`endif
      end else begin
         if (w_do_push) begin
            r_tp <= w_tp_inc;
            if (!w_full) r_cnt <= r_cnt + 1'b1;
         end
         if (w_do_pop) begin
            r_tp  <= w_tp_dec;
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_ovf_set) r_ovf <= 1'b1;
         if (w_unf_set) r_unf <= 1'b1;
`ifdef STACK_SPILL_EN
         case (r_state)
            ST_IDLE: begin
               if (w_spill_go) begin
                  r_state     <= ST_SPILL;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_msp - 1'b1;
                  r_mem_wdata <= w_rd_bot;
               end else if (w_fill_go) begin
                  r_state    <= ST_FILL;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= r_msp;
               end
            end
            ST_SPILL: begin
               // Bottom word is now in memory; the ring frees one slot
               if (mem_ack) begin
                  r_state   <= ST_IDLE;
                  r_mem_req <= 1'b0;
                  r_msp     <= r_msp - 1'b1;
                  r_cnt     <= r_cnt - 1'b1;
               end
            end
            ST_FILL: begin
               // Refilled word becomes the sole ring entry at tp
               if (mem_ack) begin
                  r_state   <= ST_IDLE;
                  r_mem_req <= 1'b0;
                  r_msp     <= r_msp + 1'b1;
                  r_cnt     <= {{DEP{1'b0}}, 1'b1};
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
`endif
      end
   end

   assign dout  = w_empty ? '0 : w_rd_top;
   assign stall = w_stall;
   assign cnt   = r_cnt;
   assign ovf   = r_ovf;
   assign unf   = r_unf;

endmodule

// File: tb/tb_stack_cache.sv
// Self-checking bench for stack_cache. Covers the plain ring by default and
// the spill/fill path when compiled with `define STACK_SPILL_EN.
`timescale 1ns/1ps
module tb_stack_cache;
   import stack_cache_pkg::*;

   localparam logic [15:0] BASE  = 16'h0800;
   localparam logic [15:0] LIMIT = 16'h0700;

   logic             clk, reset, push, pop, stall, ovf, unf, mem_req, mem_we, mem_ack;
   logic [15:0]      din, dout, mem_addr, mem_wdata, mem_rdata;
   logic [CNT_W-1:0] cnt;

   int          n_cmp, n_fail;
   logic [15:0] mdl[$];     // reference stack, last element is the top
   int          mcnt;       // reference ring occupancy
   logic [15:0] exp_q[$];   // expected dout after each driven op
   logic [15:0] mem [int];  // memory behind the cache
   int          ack_wait, wcnt;
   bit          ack_en;
`ifdef STACK_SPILL_EN
   logic [15:0] last_addr, last_wdata;
   logic        last_we;
`endif

   stack_cache #(.L(16), .DEP(DEP_DFLT), .BASE(BASE), .LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .dout(dout),
      .stall(stall), .cnt(cnt), .ovf(ovf), .unf(unf), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory responder: acks on the ack_wait-th cycle of a request
   always begin
      @(posedge clk); #1;
      if (!mem_req) begin
         mem_ack = 1'b0;
         wcnt = 0;
      end else if (ack_en && !mem_ack) begin
         wcnt++;
         if (wcnt >= ack_wait) begin
            mem_ack = 1'b1;
            if (mem_we) mem[int'(mem_addr)] = mem_wdata;
            else mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 16'hDEAD;
`ifdef STACK_SPILL_EN
            last_addr = mem_addr; last_we = mem_we; last_wdata = mem_wdata;
`endif
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void mdl_op(input logic pu, input logic po, input logic [15:0] d);
      if (pu && po) begin
         if (mcnt == 0) begin mdl.push_back(d); mcnt = 1; end
         else mdl[mdl.size()-1] = d;
      end else if (pu) begin
`ifdef STACK_SPILL_EN
         if (mcnt < N) begin mdl.push_back(d); mcnt++; end
         else if (mdl.size() - mcnt < int'(BASE - LIMIT)) mdl.push_back(d);
`else
         if (mcnt == N) void'(mdl.pop_front()); else mcnt++;
         mdl.push_back(d);
`endif
      end else if (po) begin
         if (mcnt > 0) begin void'(mdl.pop_back()); mcnt--; end
`ifdef STACK_SPILL_EN
         else if (mdl.size() > 0) void'(mdl.pop_back());
`endif
      end
   endfunction

   function automatic logic [15:0] mdl_top();
      return (mcnt == 0) ? 16'h0000 : mdl[mdl.size()-1];
   endfunction

   // Hold an op until accepted; returns the number of stalled cycles
   task automatic do_op(input logic pu, input logic po, input logic [15:0] d, output int stalls);
      push = pu; pop = po; din = d; stalls = 0;
      #1;
      while (stall && stalls < 40) begin
         @(posedge clk); #1;
         stalls++;
      end
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic drive_op(input logic pu, input logic po, input logic [15:0] d, output int stalls);
      mdl_op(pu, po, d);
      exp_q.push_back(mdl_top());
      do_op(pu, po, d, stalls);
   endtask

   task automatic do_reset();
      reset = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
      mdl.delete(); exp_q.delete(); mcnt = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (dout !== 16'h0 || cnt !== '0) begin n_fail++;
         $display("FAIL reset_dout_cnt: got %h/%0d want 0/0", dout, cnt); end
      n_cmp++; if ({ovf, unf, stall} !== 3'b000) begin n_fail++;
         $display("FAIL reset_flags: got ovf/unf/stall %b want 000", {ovf, unf, stall}); end
      n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== 34'h0) begin n_fail++;
         $display("FAIL reset_mem: got req %b we %b addr %h wdata %h want all 0", mem_req, mem_we, mem_addr, mem_wdata); end
   endtask

   task automatic test_push3();
      int st; logic [15:0] e;
      do_reset();
      for (int v = 1; v <= 3; v++) begin
         drive_op(1'b1, 1'b0, 16'(v), st);
         e = exp_q.pop_front();
         n_cmp++; if (dout !== e) begin n_fail++; $display("FAIL push3_dout: got %h want %h", dout, e); end
         n_cmp++; if (cnt !== CNT_W'(v)) begin n_fail++; $display("FAIL push3_cnt: got %0d want %0d", cnt, v); end
         n_cmp++; if (st != 0 || mem_req !== 1'b0) begin n_fail++;
            $display("FAIL push3_stall: got stalls %0d req %b want 0 0", st, mem_req); end
      end
   endtask

   task automatic test_replace();
      int st; logic [15:0] e;
      do_reset();
      for (int v = 1; v <= 4; v++) drive_op(1'b1, 1'b0, 16'(v), st);
      repeat (4) void'(exp_q.pop_front());
      drive_op(1'b1, 1'b1, 16'h0009, st);
      e = exp_q.pop_front();
      n_cmp++; if (dout !== e || cnt !== CNT_W'(4)) begin n_fail++;
         $display("FAIL replace_top: got %h/%0d want %h/4", dout, cnt, e); end
      n_cmp++; if (st != 0 || mem_req !== 1'b0 || ovf !== 1'b0) begin n_fail++;
         $display("FAIL replace_nospill: got stalls %0d req %b ovf %b want 0 0 0", st, mem_req, ovf); end
      drive_op(1'b0, 1'b1, 16'h0, st);
      e = exp_q.pop_front();
      n_cmp++; if (dout !== e) begin n_fail++; $display("FAIL replace_pop: got %h want %h", dout, e); end
   endtask

   task automatic test_push_pop_empty();
      int st; logic [15:0] e;
      do_reset();
      drive_op(1'b1, 1'b1, 16'h0077, st);
      e = exp_q.pop_front();
      n_cmp++; if (dout !== e || cnt !== CNT_W'(1)) begin n_fail++;
         $display("FAIL pushpop_empty: got %h/%0d want %h/1", dout, cnt, e); end
   endtask

   task automatic test_back_to_back();
      int st, k; logic [15:0] e, d;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         k = int'($urandom_range(0, 3));
         d = 16'($urandom);
         drive_op(k != 1, k == 1 || k == 2, d, st);
         e = exp_q.pop_front();
         n_cmp++; if (dout !== e) begin n_fail++; $display("FAIL b2b_dout[%0d]: got %h want %h", i, dout, e); end
         n_cmp++; if (cnt !== CNT_W'(mcnt)) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", i, cnt, mcnt); end
      end
   endtask

`ifndef STACK_SPILL_EN
   task automatic test_wrap();
      int st; logic [15:0] e;
      do_reset();
      for (int v = 1; v <= 5; v++) begin
         drive_op(1'b1, 1'b0, 16'(v), st);
         e = exp_q.pop_front();
         n_cmp++; if (ovf !== (v == 5)) begin n_fail++; $display("FAIL wrap_ovf[%0d]: got %b want %b", v, ovf, v == 5); end
      end
      n_cmp++; if (dout !== e || cnt !== CNT_W'(4) || mem_req !== 1'b0) begin n_fail++;
         $display("FAIL wrap_state: got %h/%0d req %b want %h/4 0", dout, cnt, mem_req, e); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (dout !== 16'(5 - i)) begin n_fail++; $display("FAIL wrap_pop[%0d]: got %h want %h", i, dout, 16'(5 - i)); end
         drive_op(1'b0, 1'b1, 16'h0, st);
         e = exp_q.pop_front();
         n_cmp++; if (dout !== e) begin n_fail++; $display("FAIL wrap_after_pop[%0d]: got %h want %h", i, dout, e); end
      end
      drive_op(1'b0, 1'b1, 16'h0, st);
      void'(exp_q.pop_front());
      n_cmp++; if (unf !== 1'b1 || cnt !== '0 || st != 0) begin n_fail++;
         $display("FAIL wrap_unf: got unf %b cnt %0d stalls %0d want 1 0 0", unf, cnt, st); end
   endtask
`else
   task automatic test_spill_fill();
      int st; logic [15:0] e;
      do_reset();
      ack_wait = 2;
      for (int v = 1; v <= 4; v++) drive_op(1'b1, 1'b0, 16'(v), st);
      repeat (4) void'(exp_q.pop_front());
      drive_op(1'b1, 1'b0, 16'h0005, st);
      e = exp_q.pop_front();
      n_cmp++; if (st != 3) begin n_fail++; $display("FAIL spill_stall: got %0d cycles want 3", st); end
      n_cmp++; if (last_addr !== 16'h07FF || last_we !== 1'b1 || last_wdata !== 16'h0001) begin n_fail++;
         $display("FAIL spill_req: got addr %h we %b data %h want 07ff 1 0001", last_addr, last_we, last_wdata); end
      n_cmp++; if (dout !== e || cnt !== CNT_W'(4) || mem_req !== 1'b0) begin n_fail++;
         $display("FAIL spill_after: got %h/%0d req %b want %h/4 0", dout, cnt, mem_req, e); end
      for (int i = 0; i < 4; i++) begin
         drive_op(1'b0, 1'b1, 16'h0, st);
         e = exp_q.pop_front();
         n_cmp++; if (dout !== e || st != 0) begin n_fail++;
            $display("FAIL fill_pre_pop[%0d]: got %h stalls %0d want %h 0", i, dout, st, e); end
      end
      // Fifth pop: fill from 07FF, observe the refilled top, then it is removed
      mdl_op(1'b0, 1'b1, 16'h0);
      pop = 1'b1; st = 0;
      #1;
      while (stall && st < 40) begin @(posedge clk); #1; st++; end
      n_cmp++; if (st != 3 || last_addr !== 16'h07FF || last_we !== 1'b0) begin n_fail++;
         $display("FAIL fill_req: got stalls %0d addr %h we %b want 3 07ff 0", st, last_addr, last_we); end
      n_cmp++; if (dout !== 16'h0001 || cnt !== CNT_W'(1)) begin n_fail++;
         $display("FAIL fill_top: got %h/%0d want 0001/1", dout, cnt); end
      @(posedge clk); #1; pop = 1'b0;
      n_cmp++; if (dout !== 16'h0 || cnt !== '0) begin n_fail++;
         $display("FAIL fill_retry: got %h/%0d want 0/0", dout, cnt); end
      // Whole stack empty now (msp back at BASE): no fill, unf set
      drive_op(1'b0, 1'b1, 16'h0, st);
      void'(exp_q.pop_front());
      #2;
      n_cmp++; if (unf !== 1'b1 || cnt !== '0 || mem_req !== 1'b0 || st != 0) begin n_fail++;
         $display("FAIL empty_unf: got unf %b cnt %0d req %b stalls %0d want 1 0 0 0", unf, cnt, mem_req, st); end
   endtask

   task automatic test_limit();
      int st; logic [15:0] e;
      do_reset();
      ack_wait = 1;
      for (int v = 1; v <= N + int'(BASE - LIMIT); v++) drive_op(1'b1, 1'b0, 16'(v), st);
      exp_q.delete();
      n_cmp++; if (last_addr !== LIMIT || last_we !== 1'b1) begin n_fail++;
         $display("FAIL limit_last_spill: got addr %h we %b want %h 1", last_addr, last_we, LIMIT); end
      n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL limit_ovf_early: got %b want 0", ovf); end
      drive_op(1'b1, 1'b0, 16'hBEEF, st);
      e = exp_q.pop_front();
      n_cmp++; if (ovf !== 1'b1 || st != 0 || mem_req !== 1'b0) begin n_fail++;
         $display("FAIL limit_ovf: got ovf %b stalls %0d req %b want 1 0 0", ovf, st, mem_req); end
      n_cmp++; if (dout !== e || cnt !== CNT_W'(4)) begin n_fail++;
         $display("FAIL limit_dropped: got %h/%0d want %h/4", dout, cnt, e); end
      ack_wait = 2;
   endtask

   task automatic test_reset_mid_spill();
      int st;
      do_reset();
      for (int v = 1; v <= 4; v++) drive_op(1'b1, 1'b0, 16'(v), st);
      exp_q.delete();
      ack_en = 1'b0;
      push = 1'b1; din = 16'h0005;
      @(posedge clk); #1;
      push = 1'b0;
      n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_fail++;
         $display("FAIL midspill_req: got req %b we %b want 1 1", mem_req, mem_we); end
      #2 reset = 1'b0;
      #1;
      n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== 34'h0 || stall !== 1'b0) begin n_fail++;
         $display("FAIL midspill_async: got req %b we %b addr %h wdata %h stall %b want 0", mem_req, mem_we, mem_addr, mem_wdata, stall); end
      n_cmp++; if (dout !== 16'h0 || cnt !== '0 || {ovf, unf} !== 2'b00) begin n_fail++;
         $display("FAIL midspill_state: got %h/%0d ovf %b unf %b want 0/0 0 0", dout, cnt, ovf, unf); end
      #2 reset = 1'b1;
      @(posedge clk); #1;
      ack_en = 1'b1;
      mdl.delete(); mcnt = 0;
   endtask
`endif

   initial begin
      reset = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
      mem_ack = 1'b0; mem_rdata = '0; ack_wait = 2; ack_en = 1'b1; wcnt = 0;
      n_cmp = 0; n_fail = 0; mcnt = 0;
      test_reset();
      test_push3();
`ifndef STACK_SPILL_EN
      test_wrap();
`else
      test_spill_fill();
      test_limit();
      test_reset_mid_spill();
`endif
      test_replace();
      test_push_pop_empty();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/stack_cache.md
# stack_cache

Parametrised successor to the b16 data/return stack: an on-chip ring of 2^DEP words with automatic spill to and fill from main memory. The CPU sees an unbounded stack and is stalled only while a spill or fill is in flight. One instance serves the data stack and one the return stack; both sit between the core and the bus arbiter.

## Interface
- L, 16: word width.
- DEP, 2: log2 of ring depth; N = 2^DEP entries.
- BASE, 16'h0800: memory stack pointer (msp) reset value; memory stack empty when msp == BASE.
- LIMIT, 16'h0700: lowest legal msp; memory stack full when msp == LIMIT.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low.
- push  in  1  push `din`; held by the requester while `stall` is high.
- pop  in  1  discard top; held while `stall` is high.
- din  in  L  word to push.
- dout  out  L  top of stack; 0 when the ring is empty.
- stall  out  1  combinational; the current push/pop is not accepted this cycle.
- cnt  out  DEP+1  ring occupancy, 0..N.
- ovf  out  1  sticky; a push was lost.
- unf  out  1  sticky; a pop was made with the whole stack empty.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = spill write, 0 = fill read.
- mem_addr  out  L  word address.
- mem_wdata  out  L  spill data.
- mem_rdata  in  L  fill data; valid with `mem_ack`.
- mem_ack  in  1  completes the access in the cycle it is sampled high.

## Operation
- Ring state:
  - tp: DEP-bit top index.
  - cnt: occupancy.
  - bottom index is tp - cnt + 1, modulo N.
- push only, cnt < N: write ring[tp+1], tp++, cnt++.
- pop only, cnt > 0: tp--, cnt--.
- push & pop together: overwrite ring[tp]. cnt and tp are unchanged. Never spills or fills. If cnt == 0, it acts as a push.
- FSM states: IDLE, SPILL, FILL.
- IDLE → SPILL: on push-only with cnt == N and msp != LIMIT.
  - mem_we = 1.
  - mem_addr = msp - 1.
  - mem_wdata = ring[bottom].
- SPILL → IDLE: on mem_ack. Then msp--, cnt--. The held push completes on the next accepted cycle.
- Push-only with cnt == N and msp == LIMIT: set ovf, drop the push, no stall.
- IDLE → FILL: on pop-only with cnt == 0 and msp != BASE.
  - mem_we = 0.
  - mem_addr = msp.
- FILL → IDLE: on mem_ack. Then write ring[tp] = mem_rdata (the refilled word is the new top), msp++, cnt = 1. The held pop then removes it.
- Pop-only with cnt == 0 and msp == BASE: set unf, ignore the pop.
- `stall` = (state != IDLE) | the IDLE condition that triggers SPILL or FILL this cycle.
- Pointer arithmetic: tp and bottom index wrap modulo N; msp is L-bit and never wraps past BASE or LIMIT.

## Timing
- Reset values: tp = 0, cnt = 0, msp = BASE, state = IDLE, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, ovf = 0, unf = 0, dout = 0.
- Unstalled push/pop: single cycle; `dout` reflects the new top after the same edge.
- Spill/fill latency: mem_req rises on the edge after the triggering cycle. Total = 1 + memory wait cycles + 1 (the retried op).
- mem_req, mem_we, mem_addr and mem_wdata are registered and stable from request to ack. mem_req drops on the edge that samples mem_ack.
- mem_ack seen in IDLE is ignored.
- Reset asserted mid-spill/fill: mem_req drops immediately (asynchronous); the transfer is abandoned.

## Configuration
- STACK_SPILL_EN defined: spill/fill behaviour as above.
- STACK_SPILL_EN undefined:
  - Pure ring, matching the legacy stack; mem_* outputs tied to 0 and `stall` tied to 0.
  - Push at cnt == N overwrites the oldest entry, sets ovf, cnt stays N.
  - Pop at cnt == 0 sets unf and leaves tp and cnt unchanged.

## Structure
- Package stack_cache_pkg holds:
  - the FSM state enum (IDLE, SPILL, FILL);
  - the localparam N;
  - the cnt width.
- Sub-module stack_ring: 2^DEP × L register array with one synchronous write port and two asynchronous read ports (top, bottom). It is reused by the return stack.

## Test plan
- Reset, then push 1, 2, 3 → dout = 3, cnt = 3, stall never high, mem_req = 0.
- N = 4, push 1..5 → spill of word 1 to address 16'h07FF, msp = 16'h07FF, cnt = 4, dout = 5. With mem_ack after 2 waits, stall is high for 3 cycles.
- Continue from the previous case: pop 5 times → 4, 3, 2 then a fill read at 16'h07FF returning 1 gives dout = 1; the fifth pop empties the stack, msp = BASE.
- Pop with the stack fully empty → unf = 1, cnt = 0, mem_req = 0. Push & pop at cnt = 4 → top replaced, no spill.
- Fill the memory stack to LIMIT, then push at cnt = 4 → ovf = 1, push dropped, stall low. Reset during SPILL → mem_req low asynchronously, all outputs at reset values.
- STACK_SPILL_EN undefined: push 1..5 → ovf = 1, cnt = 4, pop order 5, 4, 3, 2, mem_req stays 0.
